load_arbiter: RTL and testbench

LOAD_ARBITER -- requirements
Module: load_arbiter

---
 rtl/load_arbiter.sv | 128 ++++++++++++
 tb/tb_load_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_arbiter.sv
// load_arbiter: fills two buffers from two valid/ready streams through one shared
// write port. Each load phase accepts exactly A_WORDS words from stream a and
// B_WORDS words from stream b. When both streams have a word pending, the
// streams take turns (round-robin). data_ready pulses for one cycle once every
// write of the phase has been issued.
//
// Ports
//   clk, rst_in           clock; synchronous active-high reset
//   start_load            begins a load phase (only honoured in IDLE)
//   a_valid/a_data/a_ready  stream a handshake
//   b_valid/b_data/b_ready  stream b handshake
//   buf_we/buf_sel/buf_addr/buf_wdata  registered buffer write port (sel 0 = a, 1 = b)
//   data_ready            one-cycle pulse in DONE
//   busy                  high in FILL and DONE
module load_arbiter #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned A_WORDS    = 64,
   parameter int unsigned B_WORDS    = 576
) (
   input  logic                  clk,
   input  logic                  rst_in,
   input  logic                  start_load,
   input  logic                  a_valid,
   input  logic [DATA_WIDTH-1:0] a_data,
   output logic                  a_ready,
   input  logic                  b_valid,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  b_ready,
   output logic                  buf_we,
   output logic                  buf_sel,
   output logic [ADDR_WIDTH-1:0] buf_addr,
   output logic [DATA_WIDTH-1:0] buf_wdata,
   output logic                  data_ready,
   output logic                  busy
);

   localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] A_LAST = CNT_WIDTH'(A_WORDS);
   localparam logic [CNT_WIDTH-1:0] B_LAST = CNT_WIDTH'(B_WORDS);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic PRIO_A = 1'b0;
   localparam logic PRIO_B = 1'b1;

   logic [1:0]           state;
   logic [1:0]           state_next;
   logic [CNT_WIDTH-1:0] a_cnt;
   logic [CNT_WIDTH-1:0] b_cnt;
   logic                 prio;

   logic fill;
   logic a_done;
   logic b_done;
   logic a_req;
   logic b_req;
   logic a_acc;
   logic b_acc;

   always_comb begin
      fill   = (state == ST_FILL);
      a_done = (a_cnt == A_LAST);
      b_done = (b_cnt == B_LAST);
      a_req  = fill & a_valid & ~a_done;
      b_req  = fill & b_valid & ~b_done;
      // A stream may go whenever the other has nothing pending, otherwise only on its turn,
      // so at most one word is accepted per cycle.
      a_ready = fill & ~a_done & (~b_req | (prio == PRIO_A));
      b_ready = fill & ~b_done & (~a_req | (prio == PRIO_B));
      a_acc   = a_valid & a_ready;
      b_acc   = b_valid & b_ready;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start_load) state_next = ST_FILL;
         ST_FILL: if (a_done && b_done) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state     <= ST_IDLE;
         a_cnt     <= '0;
         b_cnt     <= '0;
         prio      <= PRIO_A;
         buf_we    <= 1'b0;
         buf_sel   <= 1'b0;
         buf_addr  <= '0;
         buf_wdata <= '0;
      end else begin
         state <= state_next;

         if (state == ST_IDLE && start_load) begin
            a_cnt <= '0;
            b_cnt <= '0;
         end else begin
            if (a_acc) a_cnt <= a_cnt + 1'b1;
            if (b_acc) b_cnt <= b_cnt + 1'b1;
         end

         if (a_acc)      prio <= PRIO_B;
         else if (b_acc) prio <= PRIO_A;

         // Write port lags the accept by one cycle; sel/addr/wdata hold when idle.
         buf_we <= a_acc | b_acc;
         if (a_acc) begin
            buf_sel   <= 1'b0;
            buf_addr  <= a_cnt[ADDR_WIDTH-1:0];
            buf_wdata <= a_data;
         end else if (b_acc) begin
            buf_sel   <= 1'b1;
            buf_addr  <= b_cnt[ADDR_WIDTH-1:0];
            buf_wdata <= b_data;
         end
      end
   end

   assign data_ready = (state == ST_DONE);
   assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_load_arbiter.sv
module tb_load_arbiter;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 4;

   logic          clk = 1'b0;
   logic          rst_in = 1'b1;
   logic          start_load = 1'b0;
   logic          a_valid = 1'b0;
   logic [DW-1:0] a_data = '0;
   logic          a_ready;
   logic          b_valid = 1'b0;
   logic [DW-1:0] b_data = '0;
   logic          b_ready;
   logic          buf_we;
   logic          buf_sel;
   logic [AW-1:0] buf_addr;
   logic [DW-1:0] buf_wdata;
   logic          data_ready;
   logic          busy;

   int checks = 0;
   int failures = 0;

   load_arbiter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .A_WORDS    (4),
      .B_WORDS    (6)
   ) dut (
      .clk        (clk),
      .rst_in     (rst_in),
      .start_load (start_load),
      .a_valid    (a_valid),
      .a_data     (a_data),
      .a_ready    (a_ready),
      .b_valid    (b_valid),
      .b_data     (b_data),
      .b_ready    (b_ready),
      .buf_we     (buf_we),
      .buf_sel    (buf_sel),
      .buf_addr   (buf_addr),
      .buf_wdata  (buf_wdata),
      .data_ready (data_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_in     = 1'b1;
      start_load = 1'b0;
      a_valid    = 1'b0;
      b_valid    = 1'b0;
      tick();
      tick();
      rst_in = 1'b0;
   endtask

   task automatic start_phase();
      start_load = 1'b1;
      tick();
      start_load = 1'b0;
   endtask

   int exp_sel[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 1};
   int exp_adr[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 5};
   logic [31:0] a_pat = 32'b1011_0010_1101_0001_0110_1001_1100_1011;
   logic [31:0] b_pat = 32'b0110_1101_0011_1010_1001_0111_0101_1100;

   initial begin
      int   ai;
      int   bi;
      int   a_wr;
      int   b_wr;
      logic a_fire;
      logic b_fire;
      logic done_seen;

      // Reset values, and valid ignored in IDLE.
      do_reset();
      a_valid = 1'b1;
      b_valid = 1'b1;
      tick();
      chk1("rst_data_ready", data_ready, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_a_ready", a_ready, 1'b0);
      chk1("rst_b_ready", b_ready, 1'b0);
      chk1("rst_buf_we", buf_we, 1'b0);
      chk1("rst_buf_sel", buf_sel, 1'b0);
      chk16("rst_buf_addr", 16'(buf_addr), 16'h0);
      chk16("rst_buf_wdata", buf_wdata, 16'h0);
      a_valid = 1'b0;
      b_valid = 1'b0;

      // a stream alone, then b stream completes the phase.
      a_valid = 1'b1;
      a_data  = 16'hA000;
      start_phase();
      chk1("a_only_busy", busy, 1'b1);
      for (int i = 0; i < 4; i++) begin
         a_data = 16'hA000 + 16'(i);
         #1;
         chk1("a_only_ready", a_ready, 1'b1);
         tick();
         chk1("a_only_we", buf_we, 1'b1);
         chk1("a_only_sel", buf_sel, 1'b0);
         chk16("a_only_addr", 16'(buf_addr), 16'(i));
         chk16("a_only_wdata", buf_wdata, 16'hA000 + 16'(i));
      end
      #1;
      chk1("a_done_ready", a_ready, 1'b0);
      tick();
      chk1("a_done_we", buf_we, 1'b0);
      chk1("a_done_no_dr", data_ready, 1'b0);
      tick();
      chk1("a_done_no_dr2", data_ready, 1'b0);
      chk1("a_done_busy", busy, 1'b1);
      for (int j = 0; j < 6; j++) begin
         b_valid = 1'b1;
         b_data  = 16'hB000 + 16'(j);
         #1;
         chk1("b_fill_ready", b_ready, 1'b1);
         chk1("b_fill_a_ready", a_ready, 1'b0);
         tick();
         chk1("b_fill_we", buf_we, 1'b1);
         chk1("b_fill_sel", buf_sel, 1'b1);
         chk16("b_fill_addr", 16'(buf_addr), 16'(j));
         chk16("b_fill_wdata", buf_wdata, 16'hB000 + 16'(j));
      end
      chk1("b_last_write_no_dr", data_ready, 1'b0);
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
      chk1("p1_data_ready", data_ready, 1'b1);
      chk1("p1_busy_done", busy, 1'b1);
      chk1("p1_we_done", buf_we, 1'b0);
      tick();
      chk1("p1_dr_end", data_ready, 1'b0);
      chk1("p1_busy_end", busy, 1'b0);

      // Both streams continuously valid: alternation a first, then b tail.
      do_reset();
      ai = 0;
      bi = 0;
      a_valid = 1'b1;
      b_valid = 1'b1;
      start_phase();
      for (int k = 0; k < 10; k++) begin
         a_data = 16'hA100 + 16'(ai);
         b_data = 16'hB100 + 16'(bi);
         #1;
         chk1("rr_a_ready", a_ready, exp_sel[k] == 0);
         chk1("rr_b_ready", b_ready, exp_sel[k] == 1);
         tick();
         chk1("rr_we", buf_we, 1'b1);
         chk1("rr_sel", buf_sel, exp_sel[k] == 1);
         chk16("rr_addr", 16'(buf_addr), 16'(exp_adr[k]));
         chk16("rr_wdata", buf_wdata,
               (exp_sel[k] == 1) ? 16'hB100 + 16'(exp_adr[k]) : 16'hA100 + 16'(exp_adr[k]));
         if (exp_sel[k] == 1) bi++;
         else ai++;
      end
      tick();
      chk1("rr_data_ready", data_ready, 1'b1);
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
      chk1("rr_dr_end", data_ready, 1'b0);

      // Gapped valid patterns: each address written once, in order, right data.
      do_reset();
      start_phase();
      ai = 0;
      bi = 0;
      a_wr = 0;
      b_wr = 0;
      done_seen = 1'b0;
      for (int c = 0; c < 80 && !done_seen; c++) begin
         int idx;
         idx = c % 32;
         a_valid = a_pat[idx];
         b_valid = b_pat[idx];
         a_data  = 16'hC000 + 16'(ai);
         b_data  = 16'hD000 + 16'(bi);
         #1;
         a_fire = a_valid & a_ready;
         b_fire = b_valid & b_ready;
         tick();
         if (a_fire) ai++;
         if (b_fire) bi++;
         if (buf_we) begin
            if (buf_sel == 1'b0) begin
               chk16("gap_a_addr", 16'(buf_addr), 16'(a_wr));
               chk16("gap_a_wdata", buf_wdata, 16'hC000 + 16'(a_wr));
               a_wr++;
            end else begin
               chk16("gap_b_addr", 16'(buf_addr), 16'(b_wr));
               chk16("gap_b_wdata", buf_wdata, 16'hD000 + 16'(b_wr));
               b_wr++;
            end
         end
         if (data_ready) done_seen = 1'b1;
      end
      chk1("gap_done_seen", done_seen, 1'b1);
      chk16("gap_a_writes", 16'(a_wr), 16'd4);
      chk16("gap_b_writes", 16'(b_wr), 16'd6);
      a_valid = 1'b0;
      b_valid = 1'b0;

      // Reset in the middle of FILL aborts the phase.
      do_reset();
      a_valid = 1'b1;
      start_phase();
      for (int i = 0; i < 3; i++) begin
         a_data = 16'hE000 + 16'(i);
         tick();
         chk16("abort_pre_addr", 16'(buf_addr), 16'(i));
      end
      rst_in = 1'b1;
      tick();
      chk1("abort_we", buf_we, 1'b0);
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_dr", data_ready, 1'b0);
      chk1("abort_a_ready", a_ready, 1'b0);
      rst_in = 1'b0;
      tick();
      chk1("abort_idle_busy", busy, 1'b0);
      chk1("abort_idle_dr", data_ready, 1'b0);
      start_phase();
      a_data = 16'hE100;
      tick();
      chk1("restart_we", buf_we, 1'b1);
      chk16("restart_addr", 16'(buf_addr), 16'h0);
      chk16("restart_wdata", buf_wdata, 16'hE100);
      a_valid = 1'b0;

      // start_load held through DONE: single pulse, one IDLE cycle, then FILL again.
      do_reset();
      a_valid    = 1'b1;
      b_valid    = 1'b1;
      start_load = 1'b1;
      done_seen  = 1'b0;
      for (int c = 0; c < 40 && !done_seen; c++) begin
         tick();
         if (data_ready) done_seen = 1'b1;
      end
      chk1("hold_done_seen", done_seen, 1'b1);
      tick();
      chk1("hold_dr_off", data_ready, 1'b0);
      chk1("hold_idle_busy", busy, 1'b0);
      chk1("hold_idle_a_ready", a_ready, 1'b0);
      tick();
      chk1("hold_refill_busy", busy, 1'b1);
      chk1("hold_refill_dr", data_ready, 1'b0);
      start_load = 1'b0;
      a_valid    = 1'b0;
      b_valid    = 1'b0;
      do_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
